// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Buffers ALU commands in a FIFO, drives the ALU and returns results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    cmd_sel_i,
  input  logic [3:0]    cmd_a_i,
  input  logic [3:0]    cmd_b_i,
  input  logic          cmd_chain_i,
  output logic [3:0]    alu_a_o,
  output logic [3:0]    alu_b_o,
  output logic [2:0]    alu_sel_o,
  input  logic [3:0]    alu_out_i,
  input  logic [3:0]    alu_bin_i,
  input  logic          alu_c_i,
  input  logic          alu_v_i,
  input  logic          alu_z_i,
  input  logic          alu_n_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [2:0]    rsp_sel_o,
  output logic [3:0]    rsp_data_o,
  output logic [3:0]    rsp_bin_o,
  output logic [3:0]    rsp_flags_o,
  output logic [AW:0]   fifo_level_o
);

  localparam logic [AW:0] C_LEVEL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [11:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [3:0]      last_q;

  logic            w_full, w_empty, w_push, w_pop;
  logic [11:0]     w_head;
  logic [3:0]      w_load_a;

  assign w_full       = (level_q == C_LEVEL_FULL);
  assign w_empty      = (level_q == '0);
  assign cmd_ready_o  = rst_n & ~w_full;
  assign w_push       = cmd_valid_i & cmd_ready_o;
  // A pop always coincides with loading the ALU drive registers.
  assign w_pop        = ~w_empty & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready_i));
  assign w_head       = mem_q[rd_ptr_q];
  assign w_load_a     = w_head[11] ? last_q : w_head[7:4];
  assign fifo_level_o = level_q;

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {cmd_chain_i, cmd_sel_i, cmd_a_i, cmd_b_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_sel_o   <= '0;
      rsp_data_o  <= '0;
      rsp_bin_o   <= '0;
      rsp_flags_o <= '0;
      last_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_pop) begin
            alu_a_o   <= w_load_a;
            alu_b_o   <= w_head[3:0];
            alu_sel_o <= w_head[10:8];
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_o  <= alu_out_i;
          rsp_bin_o   <= alu_bin_i;
          rsp_flags_o <= {alu_c_i, alu_v_i, alu_z_i, alu_n_i};
          rsp_sel_o   <= alu_sel_o;
          last_q      <= alu_out_i;
          rsp_valid_o <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (w_pop) begin
              alu_a_o   <= w_load_a;
              alu_b_o   <= w_head[3:0];
              alu_sel_o <= w_head[10:8];
              state_q   <= EXEC;
            end else begin
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Directed-vector bench for alu_cmd_sequencer with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_chain, rsp_ready;
  logic [2:0] cmd_sel;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_ready;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out, alu_bin;
  logic       alu_c, alu_v, alu_z, alu_n;
  logic       rsp_valid;
  logic [2:0] rsp_sel;
  logic [3:0] rsp_data, rsp_bin, rsp_flags;
  logic [2:0] fifo_level;
  logic [4:0] sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_sel_i    (cmd_sel),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_chain_i  (cmd_chain),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
    .alu_out_i    (alu_out),
    .alu_bin_i    (alu_bin),
    .alu_c_i      (alu_c),
    .alu_v_i      (alu_v),
    .alu_z_i      (alu_z),
    .alu_n_i      (alu_n),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_sel_o    (rsp_sel),
    .rsp_data_o   (rsp_data),
    .rsp_bin_o    (rsp_bin),
    .rsp_flags_o  (rsp_flags),
    .fifo_level_o (fifo_level)
  );

  // 4-bit ALU: 0 add, 1 sub (C = borrow), 2 and, 3 or, 4 xor, 5 nand, 6 xnor, 7 nor
  always_comb begin
    sum     = '0;
    alu_out = '0;
    alu_bin = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      3'd0: begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum[3:0];
        alu_c   = sum[4];
        alu_v   = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'd1: begin
        alu_out = alu_a - alu_b;
        alu_c   = (alu_a < alu_b);
        alu_v   = (alu_a[3] != alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
      3'd2:    alu_bin = alu_a & alu_b;
      3'd3:    alu_bin = alu_a | alu_b;
      3'd4:    alu_bin = alu_a ^ alu_b;
      3'd5:    alu_bin = ~(alu_a & alu_b);
      3'd6:    alu_bin = ~(alu_a ^ alu_b);
      default: alu_bin = ~(alu_a | alu_b);
    endcase
    if (alu_sel > 3'd1) alu_out = alu_bin;
    alu_z = (alu_out == 4'd0);
    alu_n = alu_out[3];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic chain, input logic [2:0] sel,
                          input logic [3:0] a, input logic [3:0] b);
    int n;
    cmd_chain = chain;
    cmd_sel   = sel;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_wait", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic get_rsp(input string tag, input logic [2:0] sel, input logic [3:0] data,
                         input logic [3:0] bin, input logic [3:0] flags);
    rsp_ready = 1'b1;
    wait_rsp();
    check_eq({tag, "_sel"},   {29'b0, rsp_sel},   {29'b0, sel});
    check_eq({tag, "_data"},  {28'b0, rsp_data},  {28'b0, data});
    check_eq({tag, "_bin"},   {28'b0, rsp_bin},   {28'b0, bin});
    check_eq({tag, "_flags"}, {28'b0, rsp_flags}, {28'b0, flags});
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Wrap-test vectors: sel, a, b, expected data, bin, flags {C,V,Z,N}
  logic [2:0] v_sel  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0, 3'd1, 3'd5, 3'd6};
  logic [3:0] v_a    [10] = '{4'h2, 4'h5, 4'hC, 4'h1, 4'hF, 4'h0, 4'hF, 4'h8, 4'hF, 4'h3};
  logic [3:0] v_b    [10] = '{4'h3, 4'h3, 4'hA, 4'h2, 4'hF, 4'h0, 4'h1, 4'h1, 4'hF, 4'h5};
  logic [3:0] v_data [10] = '{4'h5, 4'h2, 4'h8, 4'h3, 4'h0, 4'hF, 4'h0, 4'h7, 4'h0, 4'h9};
  logic [3:0] v_bin  [10] = '{4'h0, 4'h0, 4'h8, 4'h3, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h9};
  logic [3:0] v_flag [10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h1, 4'hA, 4'h4, 4'h2, 4'h1};

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    cmd_sel   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'b0, cmd_ready}, 32'd0);
    check_eq("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_level", {29'b0, fifo_level}, 32'd0);
    check_eq("rst_alu_a", {28'b0, alu_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", {31'b0, cmd_ready}, 32'd1);

    // Latency of a single add
    push_cmd(1'b0, 3'd0, 4'd3, 4'd4);
    check_eq("t1_level_t", {29'b0, fifo_level}, 32'd1);
    check_eq("t1_valid_t", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_eq("t1_alu_a",   {28'b0, alu_a}, 32'd3);
    check_eq("t1_alu_b",   {28'b0, alu_b}, 32'd4);
    check_eq("t1_alu_sel", {29'b0, alu_sel}, 32'd0);
    check_eq("t1_valid_t1", {31'b0, rsp_valid}, 32'd0);
    check_eq("t1_level_t1", {29'b0, fifo_level}, 32'd0);
    @(negedge clk);
    check_eq("t1_valid_t2", {31'b0, rsp_valid}, 32'd1);
    get_rsp("t1", 3'd0, 4'h7, 4'h0, 4'h0);

    // Overflow / borrow flags
    push_cmd(1'b0, 3'd0, 4'd7, 4'd1);
    push_cmd(1'b0, 3'd1, 4'd0, 4'd1);
    get_rsp("t2_add", 3'd0, 4'h8, 4'h0, 4'h5);
    get_rsp("t2_sub", 3'd1, 4'hF, 4'h0, 4'h9);

    // Fill under backpressure: 1 in flight + 4 queued
    for (int i = 1; i <= 5; i++) push_cmd(1'b0, 3'd0, 4'(i), 4'(i));
    check_eq("t3_full_ready", {31'b0, cmd_ready}, 32'd0);
    check_eq("t3_full_level", {29'b0, fifo_level}, 32'd4);
    cmd_sel = 3'd0; cmd_a = 4'd7; cmd_b = 4'd7; cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t3_hold_level", {29'b0, fifo_level}, 32'd4);
      check_eq("t3_hold_data", {28'b0, rsp_data}, 32'd2);
    end
    cmd_valid = 1'b0;
    get_rsp("t3_r1", 3'd0, 4'h2, 4'h0, 4'h0);
    get_rsp("t3_r2", 3'd0, 4'h4, 4'h0, 4'h0);
    get_rsp("t3_r3", 3'd0, 4'h6, 4'h0, 4'h0);
    get_rsp("t3_r4", 3'd0, 4'h8, 4'h0, 4'h5);
    get_rsp("t3_r5", 3'd0, 4'hA, 4'h0, 4'h5);
    @(negedge clk);
    check_eq("t3_drained", {29'b0, fifo_level}, 32'd0);

    // Chained operand
    push_cmd(1'b0, 3'd0, 4'd5, 4'd5);
    push_cmd(1'b1, 3'd4, 4'd0, 4'hF);
    get_rsp("t4_add", 3'd0, 4'hA, 4'h0, 4'h5);
    get_rsp("t4_chain", 3'd4, 4'h5, 4'h5, 4'h0);

    // Simultaneous push and pop at level 2
    push_cmd(1'b0, 3'd0, 4'd1, 4'd1);
    push_cmd(1'b0, 3'd0, 4'd2, 4'd2);
    push_cmd(1'b0, 3'd0, 4'd3, 4'd3);
    wait_rsp();
    check_eq("t5_pre_level", {29'b0, fifo_level}, 32'd2);
    check_eq("t5_head_data", {28'b0, rsp_data}, 32'd2);
    cmd_sel = 3'd0; cmd_a = 4'd4; cmd_b = 4'd4; cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    check_eq("t5_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check_eq("t5_level", {29'b0, fifo_level}, 32'd2);
    check_eq("t5_valid", {31'b0, rsp_valid}, 32'd0);
    get_rsp("t5_b", 3'd0, 4'h4, 4'h0, 4'h0);
    get_rsp("t5_c", 3'd0, 4'h6, 4'h0, 4'h0);
    get_rsp("t5_d", 3'd0, 4'h8, 4'h0, 4'h5);

    // Ten ops to wrap the pointers
    for (int i = 0; i < 10; i++) begin
      push_cmd(1'b0, v_sel[i], v_a[i], v_b[i]);
      get_rsp($sformatf("wrap%0d", i), v_sel[i], v_data[i], v_bin[i], v_flag[i]);
    end

    // Reset while a response is held with three queued
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 3'd3, 4'(i), 4'd8);
    wait_rsp();
    check_eq("t6_pre_level", {29'b0, fifo_level}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("t6_level", {29'b0, fifo_level}, 32'd0);
    check_eq("t6_ready", {31'b0, cmd_ready}, 32'd0);
    check_eq("t6_alu_a", {28'b0, alu_a}, 32'd0);
    check_eq("t6_data", {28'b0, rsp_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_post_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("t6_post_level", {29'b0, fifo_level}, 32'd0);
    push_cmd(1'b0, 3'd7, 4'd0, 4'd0);
    get_rsp("t6_after", 3'd7, 4'hF, 4'hF, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
